// File: rtl/button_pkg.sv
// Shared types and default timing constants for the button debouncer.
// Channel state encoding is fixed so traces stay comparable to older captures.
package button_pkg;

  typedef logic [1:0] chan_state_t;

  localparam chan_state_t UP        = 2'd0;
  localparam chan_state_t WAIT_DOWN = 2'd1;
  localparam chan_state_t DOWN      = 2'd2;
  localparam chan_state_t WAIT_UP   = 2'd3;

  // Defaults assume a 12 MHz system clock: 10 ms debounce, 1 s long-press.
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 120000;
  localparam int unsigned LONG_CYCLES_DEF     = 12000000;

endpackage

// File: rtl/button_debounce_if.sv
// Button bundle: raw levels in, debounced level and event pulses out.
// The debouncer takes the slave side; the board/bench side takes master.
interface button_debounce_if #(
  parameter int N_BTN = 4
);

  logic [N_BTN-1:0] BTN;
  logic [N_BTN-1:0] BTN_LEVEL;
  logic [N_BTN-1:0] BTN_PRESS;
  logic [N_BTN-1:0] BTN_RELEASE;
  logic [N_BTN-1:0] BTN_LONG;

  modport master (
    output BTN,
    input  BTN_LEVEL,
    input  BTN_PRESS,
    input  BTN_RELEASE,
    input  BTN_LONG
  );

  modport slave (
    input  BTN,
    output BTN_LEVEL,
    output BTN_PRESS,
    output BTN_RELEASE,
    output BTN_LONG
  );

endinterface

// File: rtl/button_debounce_chan.sv
// One debounce channel: 2-flop synchronizer, 4-state FSM, debounce counter,
// registered outputs. Long-press hold counter only with BUTTON_DEBOUNCE_LONGPRESS_EN.
module button_debounce_chan
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
`ifdef BUTTON_DEBOUNCE_LONGPRESS_EN
  , parameter int unsigned LONG_CYCLES = LONG_CYCLES_DEF
`endif
) (
  input  logic CLK,
  input  logic RST,
  input  logic btn_raw,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  chan_state_t      state;
  chan_state_t      state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             level_q;
  logic             press_q;
  logic             release_q;

  // The counter stops at CNT_LAST because reaching it always leaves the wait state.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latch can form.
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      UP: begin
        if (sync2) begin
          state_nxt = WAIT_DOWN;
          cnt_nxt   = '0;
        end
      end
      WAIT_DOWN: begin
        if (!sync2)                state_nxt = UP;
        else if (cnt == CNT_LAST)  state_nxt = DOWN;
        else                       cnt_nxt   = cnt + 1'b1;
      end
      DOWN: begin
        if (!sync2) begin
          state_nxt = WAIT_UP;
          cnt_nxt   = '0;
        end
      end
      WAIT_UP: begin
        if (sync2)                 state_nxt = DOWN;
        else if (cnt == CNT_LAST)  state_nxt = UP;
        else                       cnt_nxt   = cnt + 1'b1;
      end
      default: state_nxt = UP;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      state     <= UP;
      cnt       <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of its source.
      sync1     <= btn_raw;
      sync2     <= sync1;
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      level_q   <= (state_nxt == DOWN) || (state_nxt == WAIT_UP);
      press_q   <= (state == WAIT_DOWN) && (state_nxt == DOWN);
      release_q <= (state == WAIT_UP) && (state_nxt == UP);
    end
  end

  assign level         = level_q;
  assign press         = press_q;
  assign release_pulse = release_q;

`ifdef BUTTON_DEBOUNCE_LONGPRESS_EN
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  logic [HOLD_W-1:0] hold_cnt;
  logic              long_done;
  logic              long_q;

  // Hold time accrues only in DOWN; WAIT_UP pauses it, and only a fresh press restarts it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hold_cnt  <= '0;
      long_done <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      long_q <= 1'b0;
      if ((state == WAIT_DOWN) && (state_nxt == DOWN)) begin
        hold_cnt  <= '0;
        long_done <= 1'b0;
      end else if (state == DOWN) begin
        if (hold_cnt != HOLD_LAST) begin
          hold_cnt <= hold_cnt + 1'b1;
        end else if (!long_done) begin
          long_q    <= 1'b1;
          long_done <= 1'b1;
        end
      end
    end
  end

  assign long_pulse = long_q;
`else
  assign long_pulse = 1'b0;
`endif

endmodule

// File: rtl/button_debounce.sv
// Multi-channel button debouncer: N_BTN independent channels behind one interface.
// Define BUTTON_DEBOUNCE_LONGPRESS_EN to enable the per-channel long-press pulse.
module button_debounce
  import button_pkg::*;
#(
  parameter int unsigned N_BTN           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  button_debounce_if.slave   btn_if
);

  // Reject illegal timing at elaboration rather than build a broken counter.
  if ((DEBOUNCE_CYCLES < 2) || (DEBOUNCE_CYCLES > 32'h00FF_FFFF)) begin : g_bad_debounce
    $error("button_debounce: DEBOUNCE_CYCLES out of range 2..2^24-1");
  end
  if (LONG_CYCLES < 2) begin : g_bad_long
    $error("button_debounce: LONG_CYCLES must be at least 2");
  end

  logic [N_BTN-1:0] level_w;
  logic [N_BTN-1:0] press_w;
  logic [N_BTN-1:0] release_w;
  logic [N_BTN-1:0] long_w;

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    button_debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BUTTON_DEBOUNCE_LONGPRESS_EN
      , .LONG_CYCLES   (LONG_CYCLES)
`endif
    ) u_chan (
      .CLK           (CLK),
      .RST           (RST),
      .btn_raw       (btn_if.BTN[i]),
      .level         (level_w[i]),
      .press         (press_w[i]),
      .release_pulse (release_w[i]),
      .long_pulse    (long_w[i])
    );
  end

  assign btn_if.BTN_LEVEL   = level_w;
  assign btn_if.BTN_PRESS   = press_w;
  assign btn_if.BTN_RELEASE = release_w;
  assign btn_if.BTN_LONG    = long_w;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with DEBOUNCE_CYCLES=8, LONG_CYCLES=32.
// Inputs change and outputs are checked 1 ns after each falling CLK edge.
module tb_button_debounce;

  localparam int N = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   press_cnt [N];
  int   rel_cnt   [N];
  int   long_cnt  [N];

  button_debounce_if #(.N_BTN(N)) bif ();

  button_debounce #(
    .N_BTN           (N),
    .DEBOUNCE_CYCLES (8),
    .LONG_CYCLES     (32)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .btn_if (bif.slave)
  );

  always #5 CLK = ~CLK;

  // Independent pulse tallies so stray or duplicate pulses show up in the totals.
  initial begin
    for (int i = 0; i < N; i++) begin
      press_cnt[i] = 0;
      rel_cnt[i]   = 0;
      long_cnt[i]  = 0;
    end
  end

  always @(negedge CLK) begin
    for (int i = 0; i < N; i++) begin
      if (bif.BTN_PRESS[i]   === 1'b1) press_cnt[i] <= press_cnt[i] + 1;
      if (bif.BTN_RELEASE[i] === 1'b1) rel_cnt[i]   <= rel_cnt[i] + 1;
      if (bif.BTN_LONG[i]    === 1'b1) long_cnt[i]  <= long_cnt[i] + 1;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge CLK);
      #1;
    end
  endtask

  task automatic check_vec(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_cnt(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    bif.BTN = '0;
    RST     = 1'b1;
    step(3);
    check_vec("rst_level",   bif.BTN_LEVEL,   4'b0000);
    check_vec("rst_press",   bif.BTN_PRESS,   4'b0000);
    check_vec("rst_release", bif.BTN_RELEASE, 4'b0000);
    check_vec("rst_long",    bif.BTN_LONG,    4'b0000);
    RST = 1'b0;
    step(4);

    // Clean press on channel 0: pulse lands 11 cycles after the input edge.
    bif.BTN = 4'b0001;
    step(10);
    check_vec("press0_early",       bif.BTN_PRESS, 4'b0000);
    check_vec("level0_early",       bif.BTN_LEVEL, 4'b0000);
    step(1);
    check_vec("press0_pulse",       bif.BTN_PRESS, 4'b0001);
    check_vec("level0_set",         bif.BTN_LEVEL, 4'b0001);
    step(1);
    check_vec("press0_one_cycle",   bif.BTN_PRESS, 4'b0000);
    check_vec("level0_hold",        bif.BTN_LEVEL, 4'b0001);

    // Short 5-cycle pulse on channel 1 is rejected.
    bif.BTN = 4'b0011;
    step(5);
    bif.BTN = 4'b0001;
    step(15);
    check_vec("glitch1_level",      bif.BTN_LEVEL, 4'b0001);
    check_cnt("glitch1_no_press",   press_cnt[1], 0);

    // 3-cycle low glitch while channel 0 is held: no release.
    bif.BTN = 4'b0000;
    step(3);
    bif.BTN = 4'b0001;
    step(15);
    check_vec("bounce0_level",      bif.BTN_LEVEL, 4'b0001);
    check_cnt("bounce0_no_release", rel_cnt[0], 0);

    // Stable release of channel 0.
    bif.BTN = 4'b0000;
    step(10);
    check_vec("rel0_early",         bif.BTN_RELEASE, 4'b0000);
    check_vec("rel0_level_early",   bif.BTN_LEVEL,   4'b0001);
    step(1);
    check_vec("rel0_pulse",         bif.BTN_RELEASE, 4'b0001);
    check_vec("rel0_level_clear",   bif.BTN_LEVEL,   4'b0000);
    step(1);
    check_vec("rel0_one_cycle",     bif.BTN_RELEASE, 4'b0000);
    step(4);

    // Simultaneous press and release on channels 0 and 3.
    bif.BTN = 4'b1001;
    step(11);
    check_vec("press03_pulse",      bif.BTN_PRESS, 4'b1001);
    check_vec("press03_level",      bif.BTN_LEVEL, 4'b1001);
    step(1);
    check_vec("press03_one_cycle",  bif.BTN_PRESS, 4'b0000);
    bif.BTN = 4'b0000;
    step(11);
    check_vec("rel03_pulse",        bif.BTN_RELEASE, 4'b1001);
    check_vec("rel03_level",        bif.BTN_LEVEL,   4'b0000);
    step(4);

    // Reset while channel 2 is DOWN, button held through it.
    bif.BTN = 4'b0100;
    step(11);
    check_vec("press2_pulse",       bif.BTN_PRESS, 4'b0100);
    step(5);
    RST = 1'b1;
    step(1);
    check_vec("rst2_level",         bif.BTN_LEVEL,   4'b0000);
    check_vec("rst2_press",         bif.BTN_PRESS,   4'b0000);
    check_vec("rst2_release",       bif.BTN_RELEASE, 4'b0000);
    RST = 1'b0;
    step(10);
    check_vec("repress2_early",     bif.BTN_PRESS, 4'b0000);
    step(1);
    check_vec("repress2_pulse",     bif.BTN_PRESS, 4'b0100);
    check_vec("repress2_level",     bif.BTN_LEVEL, 4'b0100);
    check_cnt("rst2_no_release",    rel_cnt[2], 0);

    // Channel 2 held on: long-press pulse 32 cycles after its press, only once.
`ifdef BUTTON_DEBOUNCE_LONGPRESS_EN
    step(31);
    check_vec("long2_early",        bif.BTN_LONG, 4'b0000);
    step(1);
    check_vec("long2_pulse",        bif.BTN_LONG, 4'b0100);
    step(1);
    check_vec("long2_one_cycle",    bif.BTN_LONG, 4'b0000);
    step(30);
    check_cnt("long2_count",        long_cnt[2], 1);
    check_cnt("long3_count",        long_cnt[3], 0);
`else
    step(63);
    check_vec("long_tied",          bif.BTN_LONG, 4'b0000);
    check_cnt("long0_count",        long_cnt[0], 0);
    check_cnt("long2_count",        long_cnt[2], 0);
`endif

    bif.BTN = 4'b0000;
    step(11);
    check_vec("rel2_pulse",         bif.BTN_RELEASE, 4'b0100);
    step(3);

    check_cnt("total_press0",   press_cnt[0], 2);
    check_cnt("total_press1",   press_cnt[1], 0);
    check_cnt("total_press2",   press_cnt[2], 2);
    check_cnt("total_press3",   press_cnt[3], 1);
    check_cnt("total_release0", rel_cnt[0],   2);
    check_cnt("total_release2", rel_cnt[2],   1);
    check_cnt("total_release3", rel_cnt[3],   1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
